// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helper function for the UART
//               transmitter (state encoding, data width, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Bits per character on the serial line.
    localparam int DATA_BITS = 8;

    // Transmitter frame states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Counter width for a modulo-n counter: clog2(n) but never below one bit,
    // so a one-cycle bit period still gets a real (constant-zero) register.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_bit_timer
// Description : Bit-period counter for the UART transmitter. Counts
//               0 .. CLKS_PER_BIT-1 on every clock and strobes bit_end in the
//               last cycle of each bit period.
// Ports       : clk     - system clock (rising edge)
//               reset   - asynchronous active-high reset
//               clear   - restart the bit period (frame acceptance)
//               bit_end - high during the final cycle of the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                 c_cnt_w = cnt_width(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign bit_end = (r_cnt == c_last);

    // Free-running between frames; the clear on acceptance aligns the first
    // bit period exactly with the START state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule : uart_tx_bit_timer
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8-bit UART transmitter. Sends start bit, 8 data bits LSB
//               first, optional parity bit and 1-2 stop bits, each held for
//               CLKS_PER_BIT clock cycles.
// Ports       : clk     - system clock (rising edge)
//               reset   - asynchronous active-high reset
//               start   - transmit request, sampled only when idle
//               data    - byte to send, captured when start is accepted
//               tx_busy - high while a frame is in progress
//               tx_done - one-cycle pulse when the last stop bit completes
//               tx      - serial output, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam logic [2:0] c_last_data = 3'(DATA_BITS - 1);
    localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);
    localparam logic       c_par_odd   = (PARITY_ODD != 0);
    localparam logic       c_par_en    = (PARITY_EN != 0);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_parity;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic       w_bit_end;
    logic       w_last_stop;
    logic       w_accept;

    assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bit_idx == c_last_stop);

    // A new frame is taken either from IDLE or directly at the end of the
    // last stop bit, which gives back-to-back frames with no extra idle cycle.
    assign w_accept = start && ((r_state == ST_IDLE) || w_last_stop);

    uart_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_shift   <= data;
                        r_parity  <= (^data) ^ c_par_odd;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    // Also restores busy after a back-to-back hand-over cycle.
                    r_busy <= 1'b1;
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_last_data) begin
                            r_bit_idx <= '0;
                            if (c_par_en) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx      <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_last_stop) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_idx <= '0;
                        if (w_accept) begin
                            r_shift  <= data;
                            r_parity <= (^data) ^ c_par_odd;
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Four instances cover
//               no-parity, even parity, odd parity and a one-cycle bit period
//               with two stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [3:0] start_v;
    logic [7:0] data_v [4];
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int errors;
    int checks;

    // inst0: CPB=4, no parity, 1 stop
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .data(data_v[0]),
        .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));
    // inst1: CPB=4, even parity, 1 stop
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .data(data_v[1]),
        .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));
    // inst2: CPB=4, odd parity, 1 stop
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .data(data_v[2]),
        .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));
    // inst3: CPB=1, odd parity, 2 stops
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .data(data_v[3]),
        .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line bits: bit 0 is the first bit on the wire (start bit).
    typedef struct {
        int          inst;
        int          cpb;
        int          len;
        logic [7:0]  data;
        logic [11:0] bits;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    initial begin
        logic [11:0] cap;
        logic [11:0] cap2;
        int busy_n, done_n, done_at, idle_bad, lo_n, hi_n, hi_run;
        int i, cpb, len;

        errors  = 0;
        checks  = 0;
        reset   = 1'b1;
        start_v = '0;
        for (int k = 0; k < 4; k++) data_v[k] = 8'h00;

        vec[0] = '{0, 4, 40, 8'h35, 12'h26A};
        vec[1] = '{0, 4, 40, 8'hFF, 12'h3FE};
        vec[2] = '{0, 4, 40, 8'h00, 12'h200};
        vec[3] = '{1, 4, 44, 8'h07, 12'h60E};
        vec[4] = '{2, 4, 44, 8'h07, 12'h40E};
        vec[5] = '{1, 4, 44, 8'hA5, 12'h54A};
        vec[6] = '{3, 1, 12, 8'h81, 12'hF02};
        vec[7] = '{2, 4, 44, 8'hFF, 12'h7FE};

        repeat (3) @(negedge clk);
        check("reset_tx",   int'(tx_v[0]),   1);
        check("reset_busy", int'(busy_v[0]), 0);
        check("reset_done", int'(done_v[0]), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < NV; v++) begin
            i   = vec[v].inst;
            cpb = vec[v].cpb;
            len = vec[v].len;
            start_v[i] = 1'b1;
            data_v[i]  = vec[v].data;
            @(negedge clk);
            start_v[i] = 1'b0;
            data_v[i]  = ~vec[v].data;
            cap = '0; busy_n = 0; done_n = 0; done_at = -1; idle_bad = 0;
            for (int c = 0; c < len + 4; c++) begin
                if (c > 0) @(negedge clk);
                if (busy_v[i]) busy_n++;
                if (done_v[i]) begin done_n++; done_at = c; end
                if (c < len && (c % cpb) == cpb / 2) cap[c / cpb] = tx_v[i];
                if (c >= len && !tx_v[i]) idle_bad++;
            end
            check($sformatf("v%0d_bits", v),   int'(cap), int'(vec[v].bits));
            check($sformatf("v%0d_busy", v),   busy_n,    len);
            check($sformatf("v%0d_ndone", v),  done_n,    1);
            check($sformatf("v%0d_doneat", v), done_at,   len);
            check($sformatf("v%0d_idle", v),   idle_bad,  0);
        end

        // ---------------- start held 10 cycles, 0xFF ----------------
        start_v[0] = 1'b1;
        data_v[0]  = 8'hFF;
        @(negedge clk);
        lo_n = 0; hi_n = 0; busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 40) begin
                if (tx_v[0]) hi_n++; else lo_n++;
            end
            if (busy_v[0]) busy_n++;
            if (done_v[0]) begin done_n++; done_at = c; end
            if (c == 9) start_v[0] = 1'b0;
        end
        check("held_low",   lo_n,    4);
        check("held_high",  hi_n,    36);
        check("held_busy",  busy_n,  40);
        check("held_ndone", done_n,  1);
        check("held_at",    done_at, 40);

        // ---------------- back-to-back 0x00 then 0x55 ----------------
        start_v[0] = 1'b1;
        data_v[0]  = 8'h00;
        @(negedge clk);
        data_v[0] = 8'h55;
        cap2 = '0; busy_n = 0; done_n = 0; done_at = -1; hi_run = 0;
        for (int c = 0; c < 90; c++) begin
            if (c > 0) @(negedge clk);
            if (busy_v[0]) busy_n++;
            if (done_v[0]) begin done_n++; done_at = c; end
            if (c >= 36 && c <= 40 && tx_v[0]) hi_run++;
            if (c >= 40 && c < 80 && ((c - 40) % 4) == 2) cap2[(c - 40) / 4] = tx_v[0];
            if (c == 40) begin
                check("b2b_done_cycle", int'(done_v[0]), 1);
                check("b2b_start_bit",  int'(tx_v[0]),   0);
                check("b2b_busy_gap",   int'(busy_v[0]), 0);
                start_v[0] = 1'b0;
            end
            if (c == 41) check("b2b_busy_back", int'(busy_v[0]), 1);
        end
        check("b2b_stop_gap", hi_run,     4);
        check("b2b_bits2",    int'(cap2), 32'h2AA);
        check("b2b_ndone",    done_n,     2);
        check("b2b_lastdone", done_at,    80);
        check("b2b_busy",     busy_n,     79);

        // ---------------- start ignored while busy ----------------
        start_v[0] = 1'b1;
        data_v[0]  = 8'h81;
        @(negedge clk);
        start_v[0] = 1'b0;
        cap = '0; busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge clk);
            if (busy_v[0]) busy_n++;
            if (done_v[0]) begin done_n++; done_at = c; end
            if (c < 40 && (c % 4) == 2) cap[c / 4] = tx_v[0];
            if (c == 8)  begin start_v[0] = 1'b1; data_v[0] = 8'h12; end
            if (c == 9)  start_v[0] = 1'b0;
            if (c == 20) data_v[0] = 8'hFF;
        end
        check("ign_bits",  int'(cap), 32'h302);
        check("ign_ndone", done_n,    1);
        check("ign_at",    done_at,   40);
        check("ign_busy",  busy_n,    40);

        // ---------------- asynchronous reset mid-frame ----------------
        start_v[0] = 1'b1;
        data_v[0]  = 8'hA5;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_tx", int'(tx_v[0]), 0);
        #2 reset = 1'b1;
        #1;
        check("arst_tx",   int'(tx_v[0]),   1);
        check("arst_busy", int'(busy_v[0]), 0);
        check("arst_done", int'(done_v[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        done_n = 0; idle_bad = 0; busy_n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_v[0]) done_n++;
            if (!tx_v[0]) idle_bad++;
            if (busy_v[0]) busy_n++;
        end
        check("arst_nodone", done_n,   0);
        check("arst_idle",   idle_bad, 0);
        check("arst_nobusy", busy_n,   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised 8-bit UART transmitter.
- Serialises one byte per request as start bit, 8 data bits LSB first, optional parity and 1–2 stop bits, with a fixed bit period counted in clock cycles.
- Sits between a byte-producing client (start/data handshake) and the serial TX pin.
- Reports busy for the duration of the frame and a one-cycle done pulse at frame end.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range ≥ 1.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transmit request, level-sensitive, sampled only in IDLE.
- data  input  8  byte to send; captured in the cycle start is accepted.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.
- tx  output  1  serial line; idles high.

Behaviour:
- All outputs are registered. Reset asynchronously forces: state=IDLE, tx=1, tx_busy=0, tx_done=0, bit counter=0, cycle counter=0.
- A reset asserted mid-frame aborts the frame immediately; the line returns high and no tx_done is generated.
- States: IDLE → START → DATA → PARITY (only when PARITY_EN=1) → STOP → IDLE.
- IDLE: tx=1, tx_busy=0.
  - If start=1 at rising edge k: latch data into the shift register and compute parity from the latched byte.
  - After edge k: state=START, tx=0, tx_busy=1, cycle counter=0.
- Each bit is held for exactly CLKS_PER_BIT cycles. The cycle counter advances on every clock and wraps at CLKS_PER_BIT-1; the wrap advances the bit/state.
- DATA: 8 bits, shift register LSB first (data[0] first); bit index 0..7.
- PARITY: tx = XOR of the 8 bits for even parity, or its inverse for odd parity.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- On the edge ending the last stop bit: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length N = CLKS_PER_BIT*(1+8+PARITY_EN+STOP_BITS) cycles.
  - tx_busy is high for exactly N cycles (edges k .. k+N-1).
  - tx_done is high after edge k+N only.
- start while busy is ignored. data changes after acceptance do not affect the current frame.
- start still high in IDLE (including the cycle tx_done=1) begins a new frame at that edge: back-to-back frames with no idle gap beyond the stop bit(s).
  - In that case tx_done and the new frame's START state coincide for one cycle, and tx_busy returns to 1 at the next edge.
- CLKS_PER_BIT=1 is legal: one cycle per bit.
- The counter width is clog2(CLKS_PER_BIT), minimum 1 bit.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=8 constant
  - counter-width helper function (clog2 with minimum 1)
- One sub-module is natural: uart_tx_bit_timer. It is the CLKS_PER_BIT cycle counter that produces a bit_end strobe, with clear on frame acceptance. The FSM, shift register and parity stay in uart_tx.

Test Plan:
- Reset: assert reset mid-frame (CLKS_PER_BIT=4, data=0xA5, 10 cycles after start) → tx=1, tx_busy=0, tx_done=0 immediately (asynchronous); no done pulse afterwards.
- Basic frame: CLKS_PER_BIT=4, data=0xFF, start held 10 cycles → tx=0 for 4 cycles, then 1 for 36 cycles; tx_busy high 40 cycles; tx_done pulses once at cycle 40; no second frame.
- Bit order: CLKS_PER_BIT=4, data=0x35 → line samples at bit centres read 0,1,0,1,0,1,1,0,0,1 (start, LSB-first data, stop).
- Parity: PARITY_EN=1 with data=0x07 → parity bit=1 (even); PARITY_ODD=1 → parity bit=0; frame length 44 cycles.
- Back-to-back: start held high continuously with data=0x00, then 0x55 → second START begins in the tx_done cycle; exactly STOP_BITS*CLKS_PER_BIT high cycles between frames.
- Ignored start: pulse start with data=0x12 while busy transmitting 0x81 → only 0x81 is sent; a single tx_done pulse; data changes mid-frame have no effect.
